// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter sharing one single-port register file between requesters A and B.
// Each accepted request is sequenced IDLE -> ISSUE (-> RDWAIT for reads) and answered with a one-cycle pulse.
module reg_file_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  A_Req_Valid,
    input  logic                  A_Req_Write,
    input  logic [ADDR_WIDTH-1:0] A_Req_Addr,
    input  logic [DATA_WIDTH-1:0] A_Req_Wdata,
    output logic                  A_Req_Ready,
    output logic                  A_Rsp_Valid,
    output logic [DATA_WIDTH-1:0] A_Rsp_Data,
    output logic                  A_Rsp_Err,
    input  logic                  B_Req_Valid,
    input  logic                  B_Req_Write,
    input  logic [ADDR_WIDTH-1:0] B_Req_Addr,
    input  logic [DATA_WIDTH-1:0] B_Req_Wdata,
    output logic                  B_Req_Ready,
    output logic                  B_Rsp_Valid,
    output logic [DATA_WIDTH-1:0] B_Rsp_Data,
    output logic                  B_Rsp_Err,
    output logic                  RF_Wr_Enable,
    output logic                  RF_Rd_Enable,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic [DATA_WIDTH-1:0] RF_Wr_Data,
    input  logic [DATA_WIDTH-1:0] RF_Rd_Data,
    output logic                  Busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

    localparam int unsigned DEPTH_U = DEPTH;

    state_t state, state_nxt;
    logic   last_grant_b, grant_b, accept;
    logic   lat_write, lat_owner_b, legal;
    logic   rsp_done, rsp_err;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant_b = B_Req_Valid;
        if (A_Req_Valid && B_Req_Valid)
            grant_b = !last_grant_b;
        A_Req_Ready = (state == IDLE) && A_Req_Valid && !grant_b;
        B_Req_Ready = (state == IDLE) && B_Req_Valid && grant_b;
        accept      = A_Req_Ready || B_Req_Ready;
        sel_write   = grant_b ? B_Req_Write : A_Req_Write;
        sel_addr    = grant_b ? B_Req_Addr  : A_Req_Addr;
        sel_wdata   = grant_b ? B_Req_Wdata : A_Req_Wdata;
    end

    // RF_Address doubles as the latched request address; it is loaded on the accept edge.
    assign legal = 32'(RF_Address) < DEPTH_U;

    always_comb begin
        state_nxt    = state;
        RF_Wr_Enable = 1'b0;
        RF_Rd_Enable = 1'b0;
        rsp_done     = 1'b0;
        rsp_err      = 1'b0;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                RF_Wr_Enable = lat_write && legal;
                RF_Rd_Enable = !lat_write && legal;
                rsp_err      = !legal;
                rsp_done     = lat_write || !legal;
                state_nxt    = (lat_write || !legal) ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                rsp_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            last_grant_b <= 1'b1;
            lat_write    <= 1'b0;
            lat_owner_b  <= 1'b0;
            RF_Address   <= '0;
            RF_Wr_Data   <= '0;
            A_Rsp_Valid  <= 1'b0;
            A_Rsp_Err    <= 1'b0;
            A_Rsp_Data   <= '0;
            B_Rsp_Valid  <= 1'b0;
            B_Rsp_Err    <= 1'b0;
            B_Rsp_Data   <= '0;
        end else begin
            state       <= state_nxt;
            A_Rsp_Valid <= 1'b0;
            A_Rsp_Err   <= 1'b0;
            B_Rsp_Valid <= 1'b0;
            B_Rsp_Err   <= 1'b0;
            if (accept) begin
                last_grant_b <= grant_b;
                lat_owner_b  <= grant_b;
                lat_write    <= sel_write;
                RF_Address   <= sel_addr;
                if (sel_write)
                    RF_Wr_Data <= sel_wdata;
            end
            if (rsp_done) begin
                if (lat_owner_b) begin
                    B_Rsp_Valid <= 1'b1;
                    B_Rsp_Err   <= rsp_err;
                end else begin
                    A_Rsp_Valid <= 1'b1;
                    A_Rsp_Err   <= rsp_err;
                end
            end
            if (state == RDWAIT) begin
                if (lat_owner_b)
                    B_Rsp_Data <= RF_Rd_Data;
                else
                    A_Rsp_Data <= RF_Rd_Data;
            end
        end
    end

endmodule

// File: doc/reg_file_arbiter.md
Name: reg_file_arbiter

Overview:
- Shares one single-port 16-bit register file between two requesters, A and B, using round-robin arbitration.
- Each requester uses a valid/ready request handshake and receives a one-cycle response pulse.
- The block sequences the register file's Wr_Enable, Rd_Enable, Address and Wr_Data so that write and read enables are never asserted together.
- Sits between the two datapath masters and the register file.

Parameters:
DATA_WIDTH, 16, width of register file data
ADDR_WIDTH, 3, width of request and register file address
DEPTH, 8, number of implemented registers; addresses >= DEPTH are illegal

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
A_Req_Valid  in  1  requester A has a request
A_Req_Write  in  1  1 = write, 0 = read
A_Req_Addr  in  ADDR_WIDTH  target register
A_Req_Wdata  in  DATA_WIDTH  write data
A_Req_Ready  out  1  request A accepted this cycle
A_Rsp_Valid  out  1  one-cycle response pulse to A
A_Rsp_Data  out  DATA_WIDTH  read data; holds its value between reads
A_Rsp_Err  out  1  response is for an illegal address; qualified by A_Rsp_Valid
B_Req_Valid, B_Req_Write, B_Req_Addr, B_Req_Wdata, B_Req_Ready, B_Rsp_Valid, B_Rsp_Data, B_Rsp_Err  as for A
RF_Wr_Enable  out  1  register file write strobe
RF_Rd_Enable  out  1  register file read strobe
RF_Address  out  ADDR_WIDTH  register file address
RF_Wr_Data  out  DATA_WIDTH  register file write data
RF_Rd_Data  in  DATA_WIDTH  register file read data; valid in the cycle after the edge that samples RF_Rd_Enable=1
Busy  out  1  state != IDLE

Behaviour:
- Reset: one clock, CLK; RST is asynchronous and active-high.
  - State = IDLE; last_grant = B, so A wins the first tie.
  - All Rsp_Valid, Rsp_Err, Rsp_Data = 0; all RF_* = 0; Busy = 0; latched request cleared.
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE:
  - X_Req_Ready is combinational: X_Req_Ready = (state==IDLE) && X_Req_Valid && grant==X.
  - Grant rule: only one valid -> that requester; both valid -> the requester other than last_grant.
  - At most one Ready is high per cycle.
  - On the accept edge: latch write, addr, wdata and owner; update last_grant; go to ISSUE.
- ISSUE (exactly one cycle):
  - RF_Address = latched addr.
  - Write, legal address: RF_Wr_Enable = 1, RF_Wr_Data = latched wdata; next state IDLE. Owner's Rsp_Valid pulses in the next cycle with Rsp_Err = 0; Rsp_Data unchanged.
  - Read, legal address: RF_Rd_Enable = 1; next state RDWAIT.
  - Illegal address (addr >= DEPTH): both RF enables stay 0; next state IDLE. Owner's Rsp_Valid and Rsp_Err pulse in the next cycle; Rsp_Data unchanged.
- RDWAIT (one cycle): owner's Rsp_Data <= RF_Rd_Data at end of cycle; Rsp_Valid pulses the following cycle; next state IDLE.
- RF_Wr_Enable and RF_Rd_Enable are never high together and are 0 outside ISSUE. RF_Address and RF_Wr_Data hold their last values outside ISSUE.
- Latency, with accept edge at end of cycle 0:
  - Write: RF strobe in cycle 1; ack in cycle 2.
  - Read: strobe in cycle 1; data captured at end of cycle 2; Rsp_Valid high in cycle 3.
- A new request can be accepted in the same cycle a response pulses, since state is IDLE then.
- Rsp_* for the non-owner requester stay 0 / unchanged.
- Requester inputs are sampled only on the accept edge; changes while Busy are ignored.
- Only the owner's Rsp_Data register is updated.
- Reset mid-operation: the in-flight request is dropped with no response; RF strobes deassert immediately. The requester must reissue.
- Valid deasserted before Ready: no transaction, no state change.

Test Plan:
- Reset check: assert RST mid-cycle -> all outputs 0 asynchronously, Busy = 0; after release A wins the first tie.
- A writes 0x1234 to addr 2, then A reads addr 2 -> RF_Wr_Enable = 1 in cycle 1 with RF_Address = 2; write ack in cycle 2; read returns A_Rsp_Data = 0x1234 with Rsp_Valid in cycle 3 after its accept; B outputs untouched.
- A and B both hold reads (addr 1, addr 3) continuously -> grants alternate A, B, A, B; each Rsp_Data matches preloaded contents; RF enables never both 1.
- B writes addr 5 = 0x00FF while A stays idle -> B accepted immediately, ack in cycle 2; a later A read of addr 5 returns 0x00FF.
- With DEPTH = 6, A reads addr 7 -> no RF strobe; A_Rsp_Valid = 1 and A_Rsp_Err = 1 in cycle 2; A_Rsp_Data unchanged.
- A read accepted, RST pulsed in RDWAIT -> no A_Rsp_Valid; state IDLE, Busy = 0; reissued read completes normally.
